// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 32-bit register file, its
// write-port arbiter and the issue stage.
package regfile_pkg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

  // Round-robin preference: which requester wins when both are valid.
  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_e;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of the write-port arbiter's request channels, scoreboard
// mark/query ports and register-file write port.
//
// Handshake (channels A and B): the requester raises x_valid with x_addr and
// x_data and holds all three stable until it sees x_ready; a transfer happens
// on every cycle where x_valid && x_ready. x_ready is combinational from both
// valids and the arbiter's preference, and is never raised during reset.
interface regfile_wr_arbiter_if;
  import regfile_pkg::*;

  logic            a_valid;
  reg_addr_t       a_addr;
  reg_data_t       a_data;
  logic            a_ready;

  logic            b_valid;
  reg_addr_t       b_addr;
  reg_data_t       b_data;
  logic            b_ready;

  logic            mark_valid;
  reg_addr_t       mark_addr;

  reg_addr_t       q_addr1;
  reg_addr_t       q_addr2;
  logic            q_busy1;
  logic            q_busy2;

  logic            rf_we;
  reg_addr_t       rf_wa;
  reg_data_t       rf_wd;
  logic [NREG-1:0] busy;

  // Current arbiter preference, exposed for observation.
  pri_e            dbg_pri;

  // Requesters, issue stage and register file side.
  modport master (
    output a_valid, a_addr, a_data,
    input  a_ready,
    output b_valid, b_addr, b_data,
    input  b_ready,
    output mark_valid, mark_addr,
    output q_addr1, q_addr2,
    input  q_busy1, q_busy2,
    input  rf_we, rf_wa, rf_wd, busy,
    input  dbg_pri
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_addr, a_data,
    output a_ready,
    input  b_valid, b_addr, b_data,
    output b_ready,
    input  mark_valid, mark_addr,
    input  q_addr1, q_addr2,
    output q_busy1, q_busy2,
    output rf_we, rf_wa, rf_wd, busy,
    output dbg_pri
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Grants are combinational from the
// requests and a 1-bit preference; after any grant the preference moves to
// the loser's side. Grants are forced low while reset is asserted.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output pri_e       pri_o
);

  pri_e pri_q;
  pri_e pri_d;

  // Grant selection: a lone request always wins, a tie goes to the preferred side.
  always_comb begin
    gnt_o = 2'b00;
    if (!rst) begin
      if (req_i == 2'b11) begin
        gnt_o = (pri_q == PRI_A) ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  // Next preference points at whoever did not win; idle cycles keep it.
  always_comb begin
    pri_d = pri_q;
    if (gnt_o[0]) begin
      pri_d = PRI_B;
    end else if (gnt_o[1]) begin
      pri_d = PRI_A;
    end
  end

  // Preference register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q <= PRI_A;
    end else begin
      pri_q <= pri_d;
    end
  end

  assign pri_o = pri_q;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter with pending-write scoreboard.
// Two writeback requesters (A = ALU, B = load unit) share one write port
// through a registered write stage; busy[] tracks registers with a producer
// still outstanding so issue logic can detect read-after-write hazards.
// Widths come from regfile_pkg.
module regfile_wr_arbiter
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  regfile_wr_arbiter_if.slave  bus
);

  logic [1:0]      gnt;
  pri_e            pri;
  logic            any_gnt;
  reg_addr_t       win_addr;
  reg_data_t       win_data;

  logic            rf_we_q;
  reg_addr_t       rf_wa_q;
  reg_data_t       rf_wd_q;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (reset),
    .req_i ({bus.b_valid, bus.a_valid}),
    .gnt_o (gnt),
    .pri_o (pri)
  );

  assign bus.a_ready = gnt[0];
  assign bus.b_ready = gnt[1];
  assign bus.dbg_pri = pri;
  assign any_gnt     = |gnt;

  // Winner's address and data feed the write stage and the scoreboard clear.
  always_comb begin
    win_addr = bus.a_addr;
    win_data = bus.a_data;
    if (gnt[1]) begin
      win_addr = bus.b_addr;
      win_data = bus.b_data;
    end
  end

  // Scoreboard next state: clear on grant, then set on mark so a new
  // producer supersedes the one completing; register 0 is never busy.
  always_comb begin
    busy_d = busy_q;
    if (any_gnt) begin
      busy_d[win_addr] = 1'b0;
    end
    if (bus.mark_valid) begin
      busy_d[bus.mark_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Write stage: one-cycle write pulse per grant; writes to r0 are swallowed.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
    end else if (any_gnt) begin
      rf_we_q <= (win_addr != '0);
      rf_wa_q <= win_addr;
      rf_wd_q <= win_data;
    end else begin
      rf_we_q <= 1'b0;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.rf_we   = rf_we_q;
  assign bus.rf_wa   = rf_wa_q;
  assign bus.rf_wd   = rf_wd_q;
  assign bus.busy    = busy_q;
  assign bus.q_busy1 = busy_q[bus.q_addr1];
  assign bus.q_busy2 = busy_q[bus.q_addr2];

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: queued requesters driving A/B, a
// reference model of arbitration, write stage and scoreboard, and a monitor
// that pops expected register-file writes as they appear.
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  localparam int W = AW + DW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if bus ();

  regfile_wr_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit started = 1'b0;
  bit rst_req = 1'b1;
  bit rand_q  = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] a_pend[$];
  logic [W-1:0] b_pend[$];
  int           mark_plan[$];
  int           grant_log[$];

  // Reference state: what the DUT's registered outputs should show now.
  logic [NREG-1:0] m_busy = '0;
  logic            m_we   = 1'b0;
  reg_addr_t       m_wa   = '0;
  reg_data_t       m_wd   = '0;
  bit              last_a = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic present();
    bus.a_valid = (a_pend.size() > 0);
    {bus.a_addr, bus.a_data} = bus.a_valid ? a_pend[0] : '0;
    bus.b_valid = (b_pend.size() > 0);
    {bus.b_addr, bus.b_data} = bus.b_valid ? b_pend[0] : '0;
    bus.mark_valid = 1'b0;
    bus.mark_addr  = '0;
    if (mark_plan.size() > 0) begin
      int m;
      m = mark_plan.pop_front();
      if (m >= 0) begin
        bus.mark_valid = 1'b1;
        bus.mark_addr  = m[AW-1:0];
      end
    end
    if (rand_q) begin
      bus.q_addr1 = reg_addr_t'($urandom_range(0, NREG - 1));
      bus.q_addr2 = reg_addr_t'($urandom_range(0, NREG - 1));
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      bit acc_a;
      bit acc_b;
      @(negedge clk);
      #2;
      acc_a = bus.a_valid && bus.a_ready;
      acc_b = bus.b_valid && bus.b_ready;
      @(posedge clk);
      #1;
      if (acc_a) void'(a_pend.pop_front());
      if (acc_b) void'(b_pend.pop_front());
      reset = rst_req;
      present();
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((a_pend.size() > 0 || b_pend.size() > 0 || mark_plan.size() > 0) && t < 200) begin
      run_cycles(1);
      t++;
    end
    if (t >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: requests still pending after %0d cycles", t);
    end
    run_cycles(2);
  endtask

  // ---------------- reference model ----------------
  initial begin : model
    logic      ga;
    logic      gb;
    reg_addr_t wa;
    reg_data_t wd;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("busy",    bus.busy,    m_busy);
        chk("q_busy1", bus.q_busy1, m_busy[bus.q_addr1]);
        chk("q_busy2", bus.q_busy2, m_busy[bus.q_addr2]);
        chk("rf_we",   bus.rf_we,   m_we);
        chk("rf_wa",   bus.rf_wa,   m_wa);
        chk("rf_wd",   bus.rf_wd,   m_wd);
        chk("pri",     bus.dbg_pri, last_a);
      end
      if (reset) begin
        if (started) begin
          chk("a_ready_rst", bus.a_ready, 1'b0);
          chk("b_ready_rst", bus.b_ready, 1'b0);
        end
        m_busy = '0;
        m_we   = 1'b0;
        m_wa   = '0;
        m_wd   = '0;
        last_a = 1'b0;
      end else begin
        // Lone request wins; on a tie, whoever did not win last time wins.
        ga = bus.a_valid && (!bus.b_valid || !last_a);
        gb = bus.b_valid && !ga;
        if (started) begin
          chk("a_ready", bus.a_ready, ga);
          chk("b_ready", bus.b_ready, gb);
        end
        if (ga || gb) begin
          wa = ga ? bus.a_addr : bus.b_addr;
          wd = ga ? bus.a_data : bus.b_data;
          m_busy[wa] = 1'b0;
          m_we = (wa != 0);
          m_wa = wa;
          m_wd = wd;
          if (wa != 0) exp_q.push_back({wa, wd});
          grant_log.push_back(int'(wa));
          last_a = ga;
        end else begin
          m_we = 1'b0;
        end
        if (bus.mark_valid && bus.mark_addr != 0) m_busy[bus.mark_addr] = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (started && bus.rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: addr %0d data %0h with nothing expected", bus.rf_wa, bus.rf_wd);
        end else begin
          e = exp_q.pop_front();
          chk("sb_addr", bus.rf_wa, e[W-1:DW]);
          chk("sb_data", bus.rf_wd, e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int exp_order[8];
    exp_order = '{1, 11, 2, 12, 3, 13, 4, 14};
    bus.q_addr1 = '0;
    bus.q_addr2 = '0;
    present();
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    run_cycles(1);

    // Single A write to r5.
    rst_req = 1'b0;
    a_pend.push_back({5'd5, 32'hDEAD_BEEF});
    drain();

    // B write to r0 plus a mark of r0: handshake completes, nothing changes.
    b_pend.push_back({5'd0, 32'h0000_1234});
    mark_plan.push_back(0);
    drain();
    chk("r0_busy", bus.busy, '0);

    // Back-to-back contention strictly alternates, A first.
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      a_pend.push_back({5'(1 + i), 32'($urandom)});
      b_pend.push_back({5'(11 + i), 32'($urandom)});
    end
    drain();
    chk("order_len", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("order", grant_log[i], exp_order[i]);

    // Mark r7, then retire it with an A write.
    bus.q_addr1 = 5'd7;
    mark_plan.push_back(7);
    run_cycles(2);
    chk("mark7_busy", bus.busy[7], 1'b1);
    chk("mark7_q1", bus.q_busy1, 1'b1);
    a_pend.push_back({5'd7, 32'h7777_0007});
    drain();
    chk("clear7", bus.busy[7], 1'b0);

    // Mark and grant on r9 in the same cycle: set wins.
    a_pend.push_back({5'd9, 32'h9999_0009});
    mark_plan.push_back(9);
    drain();
    chk("set_wins9", bus.busy[9], 1'b1);

    // Build busy = 0xF0, then reset with both requesters waiting.
    a_pend.push_back({5'd9, 32'h0});
    for (int r = 4; r < 8; r++) mark_plan.push_back(r);
    drain();
    chk("busy_f0", bus.busy, 32'h0000_00F0);
    grant_log.delete();
    a_pend.push_back({5'd20, 32'hA0A0_0020});
    b_pend.push_back({5'd21, 32'hB0B0_0021});
    rst_req = 1'b1;
    run_cycles(1);
    rst_req = 1'b0;
    run_cycles(1);
    chk("post_rst_busy", bus.busy, '0);
    chk("post_rst_we", bus.rf_we, 1'b0);
    drain();
    chk("post_rst_first", (grant_log.size() > 0) ? grant_log[0] : -1, 20);

    // Randomized traffic with occasional resets.
    rand_q = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (a_pend.size() < 3 && $urandom_range(0, 2) != 0)
        a_pend.push_back({5'($urandom_range(0, NREG - 1)), 32'($urandom)});
      if (b_pend.size() < 3 && $urandom_range(0, 2) != 0)
        b_pend.push_back({5'($urandom_range(0, NREG - 1)), 32'($urandom)});
      mark_plan.push_back(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NREG - 1)) : -1);
      rst_req = ($urandom_range(0, 63) == 0);
      run_cycles(1);
    end
    rst_req = 1'b0;
    drain();
    chk("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port arbiter and scoreboard for the 32 x 32-bit register file. It shares the single register-file write port between two writeback requesters: A (ALU) and B (load unit). Grants alternate round-robin, and each winner drives the port through one registered stage. A pending-write scoreboard is kept alongside so issue logic can detect read-after-write hazards.

## Interface
Parameters:
- DW, 32, data width
- AW, 5, register address width
- NREG, 32, register count (2**AW)

Ports (all synchronous to clk):
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- a_valid  in  1  requester A has a write
- a_addr  in  AW  destination register for A
- a_data  in  DW  write data for A
- a_ready  out  1  A accepted this cycle
- b_valid  in  1  requester B has a write
- b_addr  in  AW  destination register for B
- b_data  in  DW  write data for B
- b_ready  out  1  B accepted this cycle
- mark_valid  in  1  issue stage reserves a destination
- mark_addr  in  AW  register being reserved
- q_addr1  in  AW  hazard query address, port 1
- q_addr2  in  AW  hazard query address, port 2
- q_busy1  out  1  busy[q_addr1], combinational
- q_busy2  out  1  busy[q_addr2], combinational
- rf_we  out  1  register-file write enable, registered
- rf_wa  out  AW  register-file write address, registered
- rf_wd  out  DW  register-file write data, registered
- busy  out  NREG  scoreboard bit vector, registered

## Operation
Handshake:
- A transfer completes on a cycle where x_valid && x_ready.
- x_ready is combinational from both valids and the priority pointer.
- x_ready is never asserted while reset=1.
- A requester holds valid, addr and data stable until accepted.

Arbitration (1-bit pointer `pri`, 0 = A preferred):
- Only one valid: that requester wins regardless of `pri`.
- Both valid: the preferred requester wins.
- After any grant, `pri` points at the loser's side: A wins -> pri=1, B wins -> pri=0.
- No grant: `pri` unchanged.

Write stage:
- On a grant, next cycle rf_wa/rf_wd take the winner's addr/data.
- rf_we=1 on that cycle, unless the address is 0.
- Writes to register 0 complete the handshake but produce rf_we=0.
- With no grant, rf_we=0 and rf_wa/rf_wd hold their previous values.

Scoreboard:
- A grant to address r clears busy[r].
- mark_valid with mark_addr=r sets busy[r].
- When mark and clear hit the same register in the same cycle, set wins: a new producer supersedes the old one.
- busy[0] is constant 0; a mark to register 0 is ignored.
- Marking an already-busy register leaves it busy. There is no counting; one outstanding producer per register is guaranteed upstream.

## Timing
- Reset values: rf_we=0, rf_wa=0, rf_wd=0, busy=0, pri=0; a_ready=b_ready=0 while reset=1.
- Reset mid-operation: in-flight handshakes are dropped, the scoreboard is cleared, and the first cycle after reset deasserts behaves as fresh.
- Latency: grant in cycle N -> rf_we/rf_wa/rf_wd valid in cycle N+1, asserted for exactly one cycle per grant.
- Throughput: one write per cycle. Under back-to-back contention, A and B strictly alternate.
- Scoreboard update is visible on `busy` and q_busy* in cycle N+1, the same cycle the register file performs the write.
- q_busy1/q_busy2 are combinational reads of the registered `busy`. A mark in cycle N is not visible in cycle N.

## Structure
- Shared package regfile_pkg: DW, AW, NREG constants and typedef reg_addr_t (logic [AW-1:0]).
- The register file and issue stage import the same package.
- One sub-module: rr_arbiter2 (two request inputs, two one-hot grants, internal `pri`, synchronous active-high reset).
- Write stage and scoreboard live in the top module.

## Test plan
- Reset, then a_valid=1, a_addr=5, a_data=32'hDEAD_BEEF -> a_ready=1 same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=32'hDEAD_BEEF; following cycle rf_we=0.
- Both valid for 4 cycles, A addrs 1..4, B addrs 11..14 -> grant order A1, B11, A2, B12, A3, B13, A4, B14, with the matching rf_wa sequence one cycle later.
- B write to addr 0 with data 32'h1234 -> b_ready=1, next cycle rf_we=0; mark to addr 0 -> busy stays 0.
- Scoreboard:
  - mark addr 7 in cycle N -> busy[7]=1 and q_busy1=1 (q_addr1=7) in N+1.
  - A write to addr 7 granted in M -> busy[7]=0 in M+1.
  - Same-cycle mark and grant on addr 9 -> busy[9]=1 afterwards.
- Assert reset for one cycle while both requesters are valid and busy=32'h0000_00F0 -> next cycle busy=0, rf_we=0, ready low during reset; first post-reset grant goes to A.
